// File: rtl/brisc_pkg.sv
// brisc_pkg: shared widths and enums for the memory arbiter
package brisc_pkg;
  localparam int ADDRESS_BITS = 32;
  localparam int CACHE_LINE_BITS = 128;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} mem_arb_state_e;
  typedef enum logic {ICACHE, DCACHE} mem_requester_e;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between icache fills and dcache fills/writebacks; cache req/addr/data in, ready/data out, shared mem_* port
module mem_arbiter
  import brisc_pkg::*;
#(
  parameter int ADDR_BITS = ADDRESS_BITS,
  parameter int LINE_BITS = CACHE_LINE_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 icache_req_in,
  input  logic [ADDR_BITS-1:0] icache_addr_in,
  output logic                 icache_ready_out,
  output logic [LINE_BITS-1:0] icache_data_out,
  input  logic                 dcache_req_in,
  input  logic                 dcache_write_in,
  input  logic [ADDR_BITS-1:0] dcache_addr_in,
  input  logic [LINE_BITS-1:0] dcache_wdata_in,
  output logic                 dcache_ready_out,
  output logic [LINE_BITS-1:0] dcache_data_out,
  output logic                 mem_req_out,
  output logic                 mem_write_out,
  output logic [ADDR_BITS-1:0] mem_addr_out,
  output logic [LINE_BITS-1:0] mem_wdata_out,
  input  logic                 mem_resp_in,
  input  logic [LINE_BITS-1:0] mem_rdata_in
);
  mem_arb_state_e state;
  mem_requester_e last_grant, grant;
  logic grant_any;
  always_comb begin
    grant_any = icache_req_in | dcache_req_in;
    grant = (dcache_req_in && (!icache_req_in || last_grant == ICACHE)) ? DCACHE : ICACHE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= ICACHE;
      mem_req_out <= 1'b0;
      mem_write_out <= 1'b0;
      mem_addr_out <= '0;
      mem_wdata_out <= '0;
      icache_data_out <= '0;
      dcache_data_out <= '0;
      icache_ready_out <= 1'b0;
      dcache_ready_out <= 1'b0;
    end else begin
      icache_ready_out <= 1'b0;
      dcache_ready_out <= 1'b0;
      case (state)
        IDLE: if (grant_any) begin
          state <= grant == DCACHE ? BUSY_D : BUSY_I;
          last_grant <= grant;
          mem_req_out <= 1'b1;
          mem_write_out <= grant == DCACHE && dcache_write_in;
          mem_addr_out <= grant == DCACHE ? dcache_addr_in : icache_addr_in;
          mem_wdata_out <= grant == DCACHE ? dcache_wdata_in : '0;
        end
        BUSY_I, BUSY_D: if (mem_resp_in) begin
          state <= RESP;
          mem_req_out <= 1'b0;
          if (state == BUSY_I) begin
            icache_data_out <= mem_rdata_in;
            icache_ready_out <= 1'b1;
          end else begin
            if (!mem_write_out) dcache_data_out <= mem_rdata_in;
            dcache_ready_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  import brisc_pkg::*;
  localparam int AW = 32;
  localparam int LW = 128;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic icache_req_in = 1'b0, dcache_req_in = 1'b0, dcache_write_in = 1'b0, mem_resp_in = 1'b0;
  logic [AW-1:0] icache_addr_in = '0, dcache_addr_in = '0;
  logic [LW-1:0] dcache_wdata_in = '0, mem_rdata_in = '0;
  logic icache_ready_out, dcache_ready_out, mem_req_out, mem_write_out;
  logic [LW-1:0] icache_data_out, dcache_data_out, mem_wdata_out;
  logic [AW-1:0] mem_addr_out;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .icache_req_in(icache_req_in), .icache_addr_in(icache_addr_in),
    .icache_ready_out(icache_ready_out), .icache_data_out(icache_data_out),
    .dcache_req_in(dcache_req_in), .dcache_write_in(dcache_write_in),
    .dcache_addr_in(dcache_addr_in), .dcache_wdata_in(dcache_wdata_in),
    .dcache_ready_out(dcache_ready_out), .dcache_data_out(dcache_data_out),
    .mem_req_out(mem_req_out), .mem_write_out(mem_write_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_resp_in(mem_resp_in), .mem_rdata_in(mem_rdata_in)
  );
  int checks = 0, failures = 0, cyc = 0;
  int m_who = 0;
  bit m_rs = 0, m_last = 0;
  logic e_req = 0, e_wr = 0, e_ir = 0, e_dr = 0;
  logic [AW-1:0] e_addr = '0;
  logic [LW-1:0] e_wdata = '0, e_id = '0, e_dd = '0;
  bit i_again = 0, d_again = 0, rnd = 0, fix_on = 0, spur = 0, prev_req = 0, wb_on = 0;
  logic [LW-1:0] fix_val = '0, wb_d = '0, dd_before = '0;
  int mem_lat = 5, hi_cnt = 0, hi_obs = 0, rise_cyc = 0, ready_cyc = 0, wb_bad = 0, samp = 0;
  int seen[$];
  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic chk(string tag, logic [LW-1:0] obs, logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Predict the outputs after the coming edge from the transaction rules, then
  // advance one cycle, compare, and react as the caches and memory would.
  task automatic tick();
    bit wd;
    if (reset) begin
      m_who = 0; m_rs = 0; m_last = 0;
      e_req = 0; e_wr = 0; e_addr = '0; e_wdata = '0; e_ir = 0; e_dr = 0; e_id = '0; e_dd = '0;
    end else if (m_rs) begin
      m_rs = 0; e_ir = 0; e_dr = 0;
    end else if (m_who == 0) begin
      if (icache_req_in || dcache_req_in) begin
        wd = dcache_req_in && (!icache_req_in || !m_last);
        m_who = wd ? 2 : 1;
        m_last = wd;
        e_req = 1;
        e_wr = wd && dcache_write_in;
        e_addr = wd ? dcache_addr_in : icache_addr_in;
        e_wdata = wd ? dcache_wdata_in : '0;
      end
    end else if (mem_resp_in) begin
      e_req = 0;
      if (m_who == 1) begin e_ir = 1; e_id = mem_rdata_in; end
      else begin e_dr = 1; if (!e_wr) e_dd = mem_rdata_in; end
      m_who = 0; m_rs = 1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("mem_req", mem_req_out, e_req);
    chk("mem_write", mem_write_out, e_wr);
    chk("mem_addr", mem_addr_out, e_addr);
    chk("mem_wdata", mem_wdata_out, e_wdata);
    chk("i_ready", icache_ready_out, e_ir);
    chk("d_ready", dcache_ready_out, e_dr);
    chk("i_data", icache_data_out, e_id);
    chk("d_data", dcache_data_out, e_dd);
    if (icache_ready_out) begin seen.push_back(1); ready_cyc = cyc; end
    if (dcache_ready_out) begin seen.push_back(2); ready_cyc = cyc; end
    if (mem_req_out) hi_obs++;
    if (mem_req_out && !prev_req) rise_cyc = cyc;
    prev_req = mem_req_out;
    if (wb_on && mem_req_out && (mem_write_out !== 1'b1 || mem_wdata_out !== wb_d)) wb_bad++;
    if (e_req) begin
      hi_cnt++;
      if (hi_cnt == 1 && rnd) mem_lat = $urandom_range(1, 6);
      mem_resp_in = hi_cnt == mem_lat;
    end else begin
      hi_cnt = 0;
      mem_resp_in = spur || (rnd && $urandom_range(0, 7) == 0);
    end
    mem_rdata_in = fix_on ? fix_val : rand_line();
    if (e_ir) begin
      if (i_again) icache_addr_in = $urandom(); else icache_req_in = 0;
    end else if (rnd && !icache_req_in && $urandom_range(0, 2) == 0) begin
      icache_req_in = 1; icache_addr_in = $urandom();
    end
    if (e_dr) begin
      if (d_again) dcache_addr_in = $urandom(); else dcache_req_in = 0;
    end else if (rnd && !dcache_req_in && $urandom_range(0, 2) == 0) begin
      dcache_req_in = 1; dcache_addr_in = $urandom();
      dcache_write_in = 1'($urandom_range(0, 1)); dcache_wdata_in = rand_line();
    end
  endtask
  task automatic run_until(int n, int bound, string tag);
    int k = 0;
    while (seen.size() < n && k < bound) begin tick(); k++; end
    chk(tag, seen.size() >= n, 1);
  endtask
  task automatic drain();
    int k = 0;
    i_again = 0; d_again = 0;
    while ((icache_req_in || dcache_req_in || m_who != 0 || m_rs) && k < 100) begin tick(); k++; end
    chk("drain", k < 100, 1);
    tick();
  endtask
  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask
  initial begin
    do_reset();
    chk("rst_mem_req", mem_req_out, 0);
    chk("rst_i_data", icache_data_out, 0);
    // lone icache fill, 5-cycle memory
    fix_on = 1; fix_val = {4{32'hDEAD_BEEF}}; mem_lat = 5;
    seen.delete(); hi_obs = 0;
    icache_req_in = 1; icache_addr_in = 32'h0000_1000;
    run_until(1, 30, "lone_timeout");
    tick(); tick();
    chk("lone_req_cycles", hi_obs, 5);
    chk("lone_pulses", seen.size(), 1);
    chk("lone_who", seen[0], 1);
    chk("lone_line", icache_data_out, {4{32'hDEAD_BEEF}});
    fix_on = 0;
    drain();
    // conflict straight after reset goes to dcache first
    do_reset();
    seen.delete();
    icache_req_in = 1; icache_addr_in = 32'h0000_1100;
    dcache_req_in = 1; dcache_write_in = 0; dcache_addr_in = 32'h0000_3000;
    run_until(2, 40, "conflict_timeout");
    chk("conflict_first", seen[0], 2);
    chk("conflict_second", seen[1], 1);
    drain();
    chk("conflict_pulses", seen.size(), 2);
    // fairness under continuous requests
    seen.delete();
    i_again = 1; d_again = 1;
    icache_req_in = 1; icache_addr_in = 32'h0000_1200;
    dcache_req_in = 1; dcache_addr_in = 32'h0000_3100;
    run_until(4, 80, "fair_timeout");
    for (int i = 0; i < 4; i++) chk($sformatf("fair_%0d", i), seen[i], (i % 2 == 0) ? 2 : 1);
    drain();
    // dcache writeback
    dd_before = e_dd;
    seen.delete();
    wb_d = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    wb_on = 1; wb_bad = 0;
    dcache_req_in = 1; dcache_write_in = 1; dcache_addr_in = 32'h0000_2040; dcache_wdata_in = wb_d;
    run_until(1, 30, "wb_timeout");
    tick();
    wb_on = 0;
    chk("wb_held", wb_bad, 0);
    chk("wb_who", seen[0], 2);
    chk("wb_data_kept", dcache_data_out, dd_before);
    drain();
    // spurious response while idle
    seen.delete();
    spur = 1; tick(); spur = 0; tick(); tick();
    chk("spur_no_ready", seen.size(), 0);
    // reset two cycles into a fill, late response afterwards
    mem_lat = 20;
    icache_req_in = 1; icache_addr_in = 32'h0000_4000;
    tick(); tick(); tick();
    chk("midop_busy", mem_req_out, 1);
    reset = 1; icache_req_in = 0;
    tick();
    reset = 0;
    chk("midop_req_drop", mem_req_out, 0);
    spur = 1; tick(); spur = 0; tick(); tick();
    chk("midop_no_ready", seen.size(), 0);
    chk("midop_i_data", icache_data_out, 0);
    chk("midop_addr", mem_addr_out, 0);
    // zero-wait memory: ready one edge after the first busy cycle
    mem_lat = 1;
    icache_req_in = 1; icache_addr_in = 32'h0000_5000;
    samp = cyc + 1;
    run_until(1, 20, "zw_timeout");
    chk("zw_rise", rise_cyc, samp);
    chk("zw_ready", ready_cyc, samp + 1);
    drain();
    // randomized traffic with random latency and spurious responses
    rnd = 1;
    for (int i = 0; i < 600; i++) tick();
    rnd = 0;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
